// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_set encodings, baud divider derivation,
// receiver state encoding and the receiver's sampling positions.
package uart_pkg;

  localparam int DIV_W = 16;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Sub-bit positions (16x oversampling) of the voting window and single sample.
  localparam logic [3:0] SAMPLE_START  = 4'd6;
  localparam logic [3:0] SAMPLE_END    = 4'd12;
  localparam logic [3:0] SAMPLE_SINGLE = 4'd8;
  // Bit index of the last data bit and frame tick where the stop bit is judged.
  localparam logic [3:0] LAST_DATA_BIT = 4'd8;
  localparam logic [7:0] STOP_EVAL     = 8'd156;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Baud rate in bits/s for a baud_set code; unused codes fall back to 9600.
  function automatic int baud_rate(input logic [2:0] sel);
    int rate;
    case (sel)
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_38400:  rate = 38400;
      BAUD_57600:  rate = 57600;
      BAUD_115200: rate = 115200;
      default:     rate = 9600;
    endcase
    return rate;
  endfunction

  // Prescaler terminal count: round(clk_freq / (16 * baud)) - 1.
  function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input logic [2:0] sel);
    int rate;
    int q;
    rate = baud_rate(sel);
    q    = ((clk_freq + rate * 8) / (rate * 16)) - 1;
    return q[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling prescaler: counts 0..div while enabled and emits a
// registered one-cycle tick on each wrap. Held at zero when disabled so the
// first tick after enable lands exactly div+1 cycles later.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and tick: restart from zero whenever disabled.
  always_comb begin
    if (!en) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (cnt_q == div) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + DIV_W'(1);
      tick_d = 1'b0;
    end
  end

  // Prescaler state and tick register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling.
// Build option UART_RX_MAJORITY_EN: when defined each bit is a 7-sample
// majority vote over sub-bits 6..12; otherwise a single sample at sub-bit 8.
// Both builds decide the bit at sub-bit 12, so latency is identical.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err
);

  localparam logic [DIV_W-1:0] DIV_9600   = baud_div(CLK_FREQ, BAUD_9600);
  localparam logic [DIV_W-1:0] DIV_19200  = baud_div(CLK_FREQ, BAUD_19200);
  localparam logic [DIV_W-1:0] DIV_38400  = baud_div(CLK_FREQ, BAUD_38400);
  localparam logic [DIV_W-1:0] DIV_57600  = baud_div(CLK_FREQ, BAUD_57600);
  localparam logic [DIV_W-1:0] DIV_115200 = baud_div(CLK_FREQ, BAUD_115200);

  logic             rx_s1_q, rx_s2_q, rx_hist_q;
  rx_state_e        state_q, state_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [DIV_W-1:0] div_q, div_d, div_sel_s;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             tick_raw_s, tick_s, en_s, fall_s, eval_s, bit_s;
  logic [7:0]       pos_s;

  assign en_s   = (state_q != RX_IDLE);
  assign tick_s = tick_raw_s & en_s;
  assign fall_s = rx_hist_q & ~rx_s2_q;
  assign pos_s  = tcnt_q + 8'd1;
  assign eval_s = tick_s && (pos_s[3:0] == SAMPLE_END);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en_s),
    .div  (div_q),
    .tick (tick_raw_s)
  );

  // Two-stage synchroniser plus history stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_hist_q <= 1'b1;
    end else begin
      rx_s1_q   <= rs232_rx;
      rx_s2_q   <= rx_s1_q;
      rx_hist_q <= rx_s2_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] ones_q, ones_d, ones_total_s;
  logic       in_win_s;

  assign in_win_s = tick_s && (pos_s[3:0] >= SAMPLE_START) && (pos_s[3:0] <= SAMPLE_END);

  // Count ones in the window; the vote includes the sample at the evaluation tick.
  always_comb begin
    ones_total_s = ones_q + {2'b00, rx_s2_q};
    bit_s        = (ones_total_s >= 3'd4);
    if ((state_q == RX_IDLE) || eval_s) begin
      ones_d = 3'd0;
    end else if (in_win_s && rx_s2_q) begin
      ones_d = ones_q + 3'd1;
    end else begin
      ones_d = ones_q;
    end
  end

  // Vote accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= 3'd0;
    end else begin
      ones_q <= ones_d;
    end
  end
`else
  logic samp_q, samp_d;

  // Capture one mid-bit sample; it is consumed at the evaluation tick.
  always_comb begin
    bit_s = samp_q;
    if (tick_s && (pos_s[3:0] == SAMPLE_SINGLE)) begin
      samp_d = rx_s2_q;
    end else begin
      samp_d = samp_q;
    end
  end

  // Single-sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= 1'b1;
    end else begin
      samp_q <= samp_d;
    end
  end
`endif

  // Divider select; the result is only latched while idle.
  always_comb begin
    case (baud_set)
      BAUD_9600:   div_sel_s = DIV_9600;
      BAUD_19200:  div_sel_s = DIV_19200;
      BAUD_38400:  div_sel_s = DIV_38400;
      BAUD_57600:  div_sel_s = DIV_57600;
      BAUD_115200: div_sel_s = DIV_115200;
      default:     div_sel_s = DIV_9600;
    endcase
  end

  // Receiver FSM next state, tick counter, shifter and output strobes.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    div_d   = div_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tcnt_d = 8'd0;
        div_d  = div_sel_s;
        if (fall_s) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (tick_s) begin
          tcnt_d = pos_s;
        end else begin
          tcnt_d = tcnt_q;
        end
        if (eval_s) begin
          if (bit_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (tick_s) begin
          tcnt_d = pos_s;
        end else begin
          tcnt_d = tcnt_q;
        end
        if (eval_s) begin
          shift_d = {bit_s, shift_q[7:1]};
          if (pos_s[7:4] == LAST_DATA_BIT) begin
            state_d = RX_STOP;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (tick_s) begin
          tcnt_d = pos_s;
        end else begin
          tcnt_d = tcnt_q;
        end
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (eval_s && (pos_s == STOP_EVAL)) begin
          state_d = RX_IDLE;
          if (bit_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          state_d = RX_STOP;
        end
      end
      default: begin
        state_d = RX_IDLE;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      tcnt_q  <= 8'd0;
      div_q   <= DIV_9600;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_byte = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx. Frames are driven bit-serially on the
// pin; each expected outcome is queued at the frame's start and checked
// when rx_done or frame_err pulses.
module tb_uart_byte_rx;

  localparam int CLK_HZ = 3_686_400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [2:0] baud_set = 3'd0;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  typedef struct {
    int         kind;   // 1 = rx_done, 2 = frame_err
    logic [7:0] data;
    int         start;
    int         d;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_lat;
  int   mon_kind;
  logic [7:0] glitch_exp;

  uart_byte_rx #(.CLK_FREQ(CLK_HZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs232_rx  (rx),
    .baud_set  (baud_set),
    .data_byte (data_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Prescaler terminal counts at 3.6864 MHz for each baud_set code.
  function automatic int div_of(input int b);
    case (b)
      0: return 23;
      1: return 11;
      2: return 5;
      3: return 3;
      4: return 1;
      default: return 23;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drive one 8N1 frame; bits inside [g_lo,g_hi) clk are inverted.
  task automatic drive_frame(input logic [7:0] b, input int d, input logic stop_v,
                             input int g_lo, input int g_hi, input int kind,
                             input logic [7:0] exp_b);
    int   bp;
    int   bn;
    logic v;
    exp_t e;
    bp = 16 * (d + 1);
    for (int i = 0; i < 10 * bp; i++) begin
      bn = i / bp;
      if (bn == 0) v = 1'b0;
      else if (bn == 9) v = stop_v;
      else v = b[bn-1];
      if (i >= g_lo && i < g_hi) v = ~v;
      @(negedge clk);
      rx = v;
      if (i == 0 && kind != 0) begin
        e.kind = kind; e.data = exp_b; e.start = cyc; e.d = d;
        sb_q.push_back(e);
      end
    end
  endtask

  // Output monitor: every strobe is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && (rx_done || frame_err)) begin
      check_val("exclusive_pulses", {31'd0, rx_done & frame_err}, 32'd0);
      if (sb_q.size() == 0) begin
        check_val("spurious_rx_done", {31'd0, rx_done}, 32'd0);
        check_val("spurious_frame_err", {31'd0, frame_err}, 32'd0);
      end else begin
        mon_e    = sb_q.pop_front();
        mon_kind = rx_done ? 1 : 2;
        mon_lat  = cyc - mon_e.start;
        check_val("pulse_kind", mon_kind, mon_e.kind);
        check_val("data_byte", {24'd0, data_byte}, {24'd0, mon_e.data});
        check_val("latency_in_window",
                  {31'd0, (mon_lat >= 155 * (mon_e.d + 1) + 2) && (mon_lat <= 157 * (mon_e.d + 1) + 5)},
                  32'd1);
      end
    end
  end

  initial begin
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    // Reset and idle line
    rst = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_data_byte", {24'd0, data_byte}, 32'd0);
    check_val("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check_val("reset_frame_err", {31'd0, frame_err}, 32'd0);
    idle(10000);

    // Basic receive at 9600
    baud_set = 3'd0;
    drive_frame(8'hAA, div_of(0), 1'b1, 0, 0, 1, 8'hAA); idle(500);
    drive_frame(8'h55, div_of(0), 1'b1, 0, 0, 1, 8'h55); idle(500);
    drive_frame(8'h33, div_of(0), 1'b1, 0, 0, 1, 8'h33); idle(500);
    drive_frame(8'hAF, div_of(0), 1'b1, 0, 0, 1, 8'hAF); idle(500);

    // Fastest rate, back to back
    baud_set = 3'd4;
    idle(4);
    drive_frame(8'h3C, div_of(4), 1'b1, 0, 0, 1, 8'h3C);
    drive_frame(8'hC3, div_of(4), 1'b1, 0, 0, 1, 8'hC3);
    idle(200);

    // False start: 3-tick low glitch on the idle line
    baud_set = 3'd2;
    idle(4);
    for (int i = 0; i < 3 * (div_of(2) + 1); i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(2000);
    check_val("false_start_data", {24'd0, data_byte}, {24'd0, 8'hC3});

    // 2-tick glitch centred on sub-bit 8 of data bit 3 of 0x00
    drive_frame(8'h00, div_of(2), 1'b1, 71 * (div_of(2) + 1), 73 * (div_of(2) + 1),
                1, glitch_exp);
    idle(300);

    // Framing error keeps the previous byte; next frame recovers
    drive_frame(8'h5A, div_of(2), 1'b0, 0, 0, 2, glitch_exp);
    idle(300);
    check_val("ferr_hold_data", {24'd0, data_byte}, {24'd0, glitch_exp});
    fork
      drive_frame(8'h81, div_of(2), 1'b1, 0, 0, 1, 8'h81);
      begin
        repeat (3 * 16 * (div_of(2) + 1)) @(negedge clk);
        baud_set = 3'd4;
      end
    join
    baud_set = 3'd2;
    idle(300);

    // Reset for one clock during data bit 4 of 0xFF
    fork
      drive_frame(8'hFF, div_of(2), 1'b1, 0, 0, 0, 8'h00);
      begin
        repeat (5 * 16 * (div_of(2) + 1) + 8 * (div_of(2) + 1)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("midreset_data_byte", {24'd0, data_byte}, 32'd0);
        check_val("midreset_rx_done", {31'd0, rx_done}, 32'd0);
      end
    join
    idle(300);
    drive_frame(8'h12, div_of(2), 1'b1, 0, 0, 1, 8'h12);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 5000 && sb_q.size() != 0; k++) @(negedge clk);
    check_val("scoreboard_drained", sb_q.size(), 32'd0);
    idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
